// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states, STATUS layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package int_ctrl_pkg;

   // Register select values on cfg_addr
   localparam logic [1:0] INT_REG_PENDING = 2'd0;
   localparam logic [1:0] INT_REG_MASK    = 2'd1;
   localparam logic [1:0] INT_REG_STATUS  = 2'd2;
   localparam logic [1:0] INT_REG_SWSET   = 2'd3;

   // Handshake FSM; encoding 2'd3 is unused and recovers to idle
   typedef enum logic [1:0] {
      INT_S_IDLE    = 2'd0,
      INT_S_REQ     = 2'd1,
      INT_S_SERVICE = 2'd2
   } int_state_e;

   // STATUS register word: {25'b0, state[1:0], vec[4:0]}
   typedef struct packed {
      logic [24:0] rsvd;
      logic [1:0]  state;
      logic [4:0]  vec;
   } int_status_t;

endpackage

// File: rtl/int_sync_edge.sv
// One interrupt source: SYNC_STAGES-flop synchroniser followed by a rising-edge detector.
// Latency: edge_o pulses for one cycle SYNC_STAGES edges after src_i rises.
// Backpressure: none; every synchronised rising edge yields exactly one pulse.
module int_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic src_i,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the raw source through the synchroniser and remember the last synced level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: sync/edge-detect sources, pending+mask, select one, req/ack/done handshake to the core.
// Latency: source edge to PENDING SYNC_STAGES+1 edges; nonzero candidates in idle to ir_req 1 cycle.
// Backpressure: ir_req held until ir_ack; no new request until ir_done. INT_RR_EN selects round-robin arbitration.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_i,
   output logic             ir_req,
   output logic [4:0]       ir_vec,
   input  logic             ir_ack,
   input  logic             ir_done,
   input  logic             cfg_wen,
   input  logic [1:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata
);

   logic [N_SRC-1:0] edge_w;
   logic [N_SRC-1:0] wdata_w;
   logic [N_SRC-1:0] cand_w;
   logic [31:0]      unused_wdata;

   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   int_state_e       state_q, state_d;
   logic [4:0]       vec_q, vec_d;
   int_status_t      status_w;

   // Register bits at and above N_SRC are dropped here
   assign wdata_w      = cfg_wdata[N_SRC-1:0];
   assign unused_wdata = cfg_wdata;

   genvar g;
   generate
      for (g = 0; g < N_SRC; g++) begin : g_src
         int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .src_i  (src_i[g]),
            .edge_o (edge_w[g])
         );
      end
   endgenerate

   assign cand_w = pend_q & mask_q;

`ifdef INT_RR_EN
   logic [4:0] last_q, last_d;

   // Round-robin: search starts just after the last granted index and wraps
   function automatic logic [4:0] pick_src(input logic [N_SRC-1:0] c, input logic [4:0] last);
      logic [4:0] r;
      logic       hit;
      int         idx;
      r   = '0;
      hit = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         idx = (int'(last) + 1 + k) % N_SRC;
         if (!hit && c[idx]) begin
            r   = 5'(idx);
            hit = 1'b1;
         end
      end
      return r;
   endfunction

   // Remember the most recently acknowledged source
   always_comb begin
      last_d = last_q;
      if (state_q == INT_S_REQ && ir_ack) last_d = vec_q;
   end

   // Last-grant register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_q <= '0;
      else      last_q <= last_d;
   end
`else
   // Fixed priority: the lowest set index wins
   function automatic logic [4:0] pick_src(input logic [N_SRC-1:0] c);
      logic [4:0] r;
      r = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (c[i]) r = 5'(i);
      end
      return r;
   endfunction
`endif

   // Handshake FSM next state; the request, once latched, is not withdrawn by mask/clear
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      case (state_q)
         INT_S_IDLE: begin
            if (|cand_w) begin
`ifdef INT_RR_EN
               vec_d = pick_src(cand_w, last_q);
`else
               vec_d = pick_src(cand_w);
`endif
               state_d = INT_S_REQ;
            end
         end
         INT_S_REQ: begin
            if (ir_ack) state_d = INT_S_SERVICE;
         end
         INT_S_SERVICE: begin
            if (ir_done) state_d = INT_S_IDLE;
         end
         default: state_d = INT_S_IDLE;
      endcase
   end

   // PENDING/MASK next state: clears first, then sets so a simultaneous set wins
   always_comb begin
      pend_d = pend_q;
      mask_d = mask_q;
      if (cfg_wen && cfg_addr == INT_REG_PENDING) pend_d = pend_d & ~wdata_w;
      if (state_q == INT_S_REQ && ir_ack) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (vec_q == 5'(i)) pend_d[i] = 1'b0;
         end
      end
      pend_d = pend_d | edge_w;
      if (cfg_wen && cfg_addr == INT_REG_SWSET) pend_d = pend_d | wdata_w;
      if (cfg_wen && cfg_addr == INT_REG_MASK)  mask_d = wdata_w;
   end

   // State, vector and register file
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INT_S_IDLE;
         vec_q   <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
      end
   end

   assign ir_req = (state_q == INT_S_REQ);
   assign ir_vec = vec_q;

   // Combinational register read of pre-edge values
   always_comb begin
      status_w       = '0;
      status_w.state = state_q;
      status_w.vec   = vec_q;
      cfg_rdata      = '0;
      case (cfg_addr)
         INT_REG_PENDING: cfg_rdata = 32'(pend_q);
         INT_REG_MASK:    cfg_rdata = 32'(mask_q);
         INT_REG_STATUS:  cfg_rdata = status_w;
         default:         cfg_rdata = '0;
      endcase
   end

endmodule
